// File: rtl/flash_rd_seq.sv
// Read sequencer for a serial bit-addressed flash: one word request becomes DATA_W single-bit accesses.
// Latency: DATA_W*(WAIT_CYC+2) cycles from accept edge to rsp_valid rising.
// Backpressure: req_ready only in IDLE; the response is held in DONE until rsp_ready.
//
// Ports: clk/rst_res_n (async active-low); req_valid/req_ready/req_addr request side;
//        abort cancels a read in flight; ce0/addr/dout flash side;
//        rsp_valid/rsp_ready/rsp_data response side; busy = not IDLE.
module flash_rd_seq #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_res_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              abort,
    output logic              ce0,
    output logic [ADDR_W-1:0] addr,
    input  logic              dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [3:0]       WAIT_LD  = 4'(WAIT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t              state_q,     state_d;
    logic [IDX_W-1:0]    bit_idx_q,   bit_idx_d;
    logic [3:0]          wait_cnt_q,  wait_cnt_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic                ce0_q,       ce0_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q,      busy_d;
    logic                req_ready_q, req_ready_d;
    logic                in_access;

    // SETUP/WAIT/SAMPLE form one flash access window; abort only acts there.
    assign in_access = (state_q == ST_SETUP) || (state_q == ST_WAIT) ||
                       (state_q == ST_SAMPLE);

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d     = req_addr;
                    bit_idx_d  = '0;
                    rsp_data_d = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wait_cnt_d = WAIT_LD;
                state_d    = (WAIT_CYC > 0) ? ST_WAIT : ST_SAMPLE;
            end
            ST_WAIT: begin
                // Counter enters at WAIT_CYC and leaves at 1, so WAIT spans exactly WAIT_CYC cycles.
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                rsp_data_d[bit_idx_q] = dout;
                if (bit_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    addr_d    = addr_q + 1'b1;  // natural wrap modulo 2**ADDR_W
                    state_d   = ST_SETUP;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats the SAMPLE transition: the bit under sample is not captured,
        // earlier bits stay in rsp_data.
        if (abort && in_access) begin
            state_d    = ST_IDLE;
            bit_idx_d  = bit_idx_q;
            addr_d     = addr_q;
            rsp_data_d = rsp_data_q;
        end

        // Outputs are registered from the next state so they line up with it.
        ce0_d       = (state_d == ST_SETUP) || (state_d == ST_WAIT) ||
                      (state_d == ST_SAMPLE);
        rsp_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_res_n) begin
        if (!rst_res_n) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            rsp_data_q  <= '0;
            ce0_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            rsp_data_q  <= rsp_data_d;
            ce0_q       <= ce0_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign ce0       = ce0_q;
    assign addr      = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_flash_rd_seq.sv
// Directed bench for flash_rd_seq: default instance (8 bits, 2 wait cycles) and a
// 4-bit, zero-wait instance. Flash contents are a bit vector indexed by addr.
// Outputs are sampled and inputs driven on the falling edge.
module tb_flash_rd_seq;

    logic       clk = 1'b0;
    logic       rst_res_n;

    // default instance
    logic       req_valid, req_ready, abort, ce0, dout, rsp_valid, rsp_ready, busy;
    logic [2:0] req_addr, addr;
    logic [7:0] rsp_data;
    logic [7:0] mem;

    // DATA_W=4, WAIT_CYC=0 instance
    logic       req_valid4, req_ready4, abort4, ce04, dout4, rsp_valid4, rsp_ready4, busy4;
    logic [2:0] req_addr4, addr4;
    logic [3:0] rsp_data4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dout  = mem[addr];
    assign dout4 = 1'b1;

    flash_rd_seq u_dut (
        .clk(clk), .rst_res_n(rst_res_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .abort(abort), .ce0(ce0), .addr(addr), .dout(dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    flash_rd_seq #(.ADDR_W(3), .DATA_W(4), .WAIT_CYC(0)) u_dut4 (
        .clk(clk), .rst_res_n(rst_res_n),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_addr(req_addr4),
        .abort(abort4), .ce0(ce04), .addr(addr4), .dout(dout4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one read on the default instance, starting from an IDLE falling edge.
    // Returns the cycle (0 = cycle after accept edge) where rsp_valid is first seen,
    // the number of cycles before that with ce0 low, and the address of each bit.
    task automatic do_read(input logic [2:0] a, output int lat, output int ce_low,
                           output logic [23:0] aseq);
        lat    = -1;
        ce_low = 0;
        aseq   = '0;
        req_addr  = a;
        req_valid = 1'b1;
        check("accept_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
            if (ce0 !== 1'b1) ce_low++;
            if ((c % 4) == 1 && (c / 4) < 8) aseq[3*(c/4) +: 3] = addr;
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat, ce_low, bad;
        logic [23:0] aseq, exp_seq;
        logic [7:0]  d0;

        rst_res_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; abort = 1'b0; rsp_ready = 1'b0;
        req_valid4 = 1'b0; req_addr4 = '0; abort4 = 1'b0; rsp_ready4 = 1'b0;
        mem = 8'h00;

        // 1: reset with a request pending
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ce0",       ce0,       1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_rsp_data",  rsp_data,  8'h00);
        check("rst_addr",      addr,      3'd0);
        req_valid = 1'b0;
        rst_res_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_busy",  busy,      1'b0);

        // 2: basic read, dout = addr[0]
        mem = 8'hAA;
        do_read(3'd0, lat, ce_low, aseq);
        check("basic_latency", lat,      32'd32);
        check("basic_ce0_gap", ce_low,   32'd0);
        check("basic_data",    rsp_data, 8'hAA);
        check("basic_addrseq", aseq,     24'hFAC688);  // 7,6,5,4,3,2,1,0
        check("done_ce0",      ce0,      1'b0);
        check("done_busy",     busy,     1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("basic_rsp_drop", rsp_valid, 1'b0);

        // 3: address wrap from 5, ones only at addresses 6 and 0
        mem = 8'b0100_0001;
        do_read(3'd5, lat, ce_low, aseq);
        exp_seq = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5};
        check("wrap_latency", lat,      32'd32);
        check("wrap_addrseq", aseq,     exp_seq);
        check("wrap_data",    rsp_data, 8'b0000_1010);

        // 5: backpressure in DONE with a new request waiting
        req_addr  = 3'd0;
        req_valid = 1'b1;
        d0  = rsp_data;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_data !== d0 || req_ready !== 1'b0 || ce0 !== 1'b0 || rsp_valid !== 1'b1)
                bad++;
        end
        check("bp_hold", bad, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_rsp_drop",  rsp_valid, 1'b0);
        check("bp_idle_rdy",  req_ready, 1'b1);
        check("bp_idle_busy", busy,      1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_busy", busy, 1'b1);
        check("bp_next_ce0",  ce0,  1'b1);

        // 6a: abort during WAIT of bit 3 (cycle 13 of the read just accepted)
        repeat (13) @(negedge clk);
        check("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",    busy,      1'b0);
        check("abort_ce0",     ce0,       1'b0);
        check("abort_rsp",     rsp_valid, 1'b0);
        check("abort_partial", rsp_data,  8'h01);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || ce0 !== 1'b0) bad++;
        end
        check("abort_quiet", bad, 32'd0);

        // 6b: reset pulse in SAMPLE of bit 1 (cycle 7)
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("rstmid_pre_ce0", ce0, 1'b1);
        #2 rst_res_n = 1'b0;
        #1;
        check("rstmid_ce0",   ce0,       1'b0);
        check("rstmid_busy",  busy,      1'b0);
        check("rstmid_rsp",   rsp_valid, 1'b0);
        check("rstmid_ready", req_ready, 1'b0);
        check("rstmid_data",  rsp_data,  8'h00);
        @(negedge clk);
        rst_res_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rstmid_quiet", bad,       32'd0);
        check("rstmid_ready_back", req_ready, 1'b1);

        // 4: zero-wait, 4-bit instance
        check("z_ready", req_ready4, 1'b1);
        req_addr4  = 3'd2;
        req_valid4 = 1'b1;
        @(negedge clk);
        req_valid4 = 1'b0;
        lat = -1;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid4 === 1'b1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        check("z_latency", lat,       32'd8);
        check("z_data",    rsp_data4, 4'hF);
        check("z_ce0",     ce04,      1'b0);
        rsp_ready4 = 1'b1;
        @(negedge clk);
        rsp_ready4 = 1'b0;
        check("z_rsp_drop", rsp_valid4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
